// File: rtl/blake2_compress_hs.sv
// BLAKE2b/BLAKE2s compression function F, one full round (8 G mixes) per clock,
// with valid/ready handshakes on the block input and the chaining-state output.
module blake2_compress_hs #(
  parameter int unsigned W = 64,
  parameter int unsigned R = (W == 64) ? 12 : 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [8*W-1:0]  h_i,
  input  logic [16*W-1:0] m_i,
  input  logic [2*W-1:0]  t_i,
  input  logic            f_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [8*W-1:0]  h_o
);

  localparam int unsigned R1 = (W == 64) ? 32 : 16;
  localparam int unsigned R2 = (W == 64) ? 24 : 12;
  localparam int unsigned R3 = (W == 64) ? 16 : 8;
  localparam int unsigned R4 = (W == 64) ? 63 : 7;
  localparam logic [3:0] RLast = 4'(R - 1);

  // BLAKE2s IV words are the upper halves of the BLAKE2b IV words.
  localparam logic [63:0] IV64 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  // Permutation rows; nibble j (bits 4j+3:4j) holds SIGMA[r][j].
  localparam logic [63:0] SIGMA [10] = '{
    64'hfedcba9876543210, 64'h357b20c16df984ae, 64'h491763eadf250c8b, 64'h8f04a562ebcd1397,
    64'hd386cb1efa427509, 64'h91ef57d438b0a6c2, 64'hb8293670a4def15c, 64'ha2684f05931ce7bd,
    64'h5a417d2c803b9ef6, 64'h0dc39ebf5167482a
  };

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [3:0]           rnd_q, rnd_d;
  logic [3:0]           sig_q, sig_d;
  logic                 load, step, fin;
  logic [15:0][W-1:0]   v_q, v_init, vc, vn;
  logic [15:0][W-1:0]   m_q;
  logic [7:0][W-1:0]    h_q, h_in, h_next;
  logic [63:0]          srow;

  assign h_in = h_i;

  function automatic logic [W-1:0] iv(input int unsigned k);
    logic [63:0] x;
    x = IV64[k] >> (64 - W);
    return x[W-1:0];
  endfunction

  function automatic logic [W-1:0] ror(input logic [W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (W - n));
  endfunction

  function automatic logic [4*W-1:0] g(input logic [W-1:0] a_in, input logic [W-1:0] b_in,
                                       input logic [W-1:0] c_in, input logic [W-1:0] d_in,
                                       input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] a, b, c, d;
    a = a_in + b_in + x;
    d = ror(d_in ^ a, R1);
    c = c_in + d;
    b = ror(b_in ^ c, R2);
    a = a + b + y;
    d = ror(d ^ a, R3);
    c = c + d;
    b = ror(b ^ c, R4);
    return {a, b, c, d};
  endfunction

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      v_init[k]     = h_in[k];
      v_init[k + 8] = iv(k);
    end
    v_init[12] = v_init[12] ^ t_i[W-1:0];
    v_init[13] = v_init[13] ^ t_i[2*W-1:W];
    v_init[14] = v_init[14] ^ {W{f_i}};
  end

  // Column step then diagonal step on the column results.
  always_comb begin
    srow = SIGMA[sig_q];
    vc   = v_q;
    for (int i = 0; i < 4; i++) begin
      {vc[i], vc[i+4], vc[i+8], vc[i+12]} =
        g(vc[i], vc[i+4], vc[i+8], vc[i+12], m_q[srow[8*i +: 4]], m_q[srow[8*i+4 +: 4]]);
    end
    vn = vc;
    for (int i = 0; i < 4; i++) begin
      {vn[i], vn[4+((i+1)%4)], vn[8+((i+2)%4)], vn[12+((i+3)%4)]} =
        g(vn[i], vn[4+((i+1)%4)], vn[8+((i+2)%4)], vn[12+((i+3)%4)],
          m_q[srow[32+8*i +: 4]], m_q[srow[36+8*i +: 4]]);
    end
    for (int k = 0; k < 8; k++) begin
      h_next[k] = h_q[k] ^ vn[k] ^ vn[k+8];
    end
  end

  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    sig_d   = sig_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    ready_o = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready_o = 1'b1;
        if (valid_i) begin
          load    = 1'b1;
          rnd_d   = 4'd0;
          sig_d   = 4'd0;
          state_d = StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (rnd_q == RLast) begin
          fin     = 1'b1;
          rnd_d   = 4'd0;
          sig_d   = 4'd0;
          state_d = StDone;
        end else begin
          rnd_d = rnd_q + 4'd1;
          sig_d = (sig_q == 4'd9) ? 4'd0 : sig_q + 4'd1;
        end
      end
      StDone: begin
        valid_o = 1'b1;
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      rnd_q   <= 4'd0;
      sig_q   <= 4'd0;
      h_o     <= '0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      sig_q   <= sig_d;
      if (fin) h_o <= h_next;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      h_q <= h_in;
      m_q <= m_i;
      v_q <= v_init;
    end else if (step) begin
      v_q <= vn;
    end
  end

endmodule

// File: tb/tb_blake2_compress_hs.sv
// Bench for blake2_compress_hs: a BLAKE2b and a BLAKE2s instance checked against
// an RFC 7693 reference model and known "abc" digests.
module tb_blake2_compress_hs;

  logic clk = 1'b0;
  logic reset;

  logic          v64_i, r64_o, f64_i, v64_o, rdy64_i;
  logic [511:0]  h64_i, h64_o;
  logic [1023:0] m64_i;
  logic [127:0]  t64_i;
  logic          v32_i, r32_o, f32_i, v32_o, rdy32_i;
  logic [255:0]  h32_i, h32_o;
  logic [511:0]  m32_i;
  logic [63:0]   t32_i;

  blake2_compress_hs #(.W(64), .R(12)) dut64 (
    .clk(clk), .reset(reset), .valid_i(v64_i), .ready_o(r64_o), .h_i(h64_i), .m_i(m64_i),
    .t_i(t64_i), .f_i(f64_i), .valid_o(v64_o), .ready_i(rdy64_i), .h_o(h64_o)
  );

  blake2_compress_hs #(.W(32), .R(10)) dut32 (
    .clk(clk), .reset(reset), .valid_i(v32_i), .ready_o(r32_o), .h_i(h32_i), .m_i(m32_i),
    .t_i(t32_i), .f_i(f32_i), .valid_o(v32_o), .ready_i(rdy32_i), .h_o(h32_o)
  );

  initial forever #5 clk = ~clk;

  localparam logic [63:0] IV64 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
  };

  localparam int SIG [10][16] = '{
    '{ 0,  1,  2,  3,  4,  5,  6,  7,  8,  9, 10, 11, 12, 13, 14, 15},
    '{14, 10,  4,  8,  9, 15, 13,  6,  1, 12,  0,  2, 11,  7,  5,  3},
    '{11,  8, 12,  0,  5,  2, 15, 13, 10, 14,  3,  6,  7,  1,  9,  4},
    '{ 7,  9,  3,  1, 13, 12, 11, 14,  2,  6,  5, 10,  4,  0, 15,  8},
    '{ 9,  0,  5,  7,  2,  4, 10, 15, 14,  1, 11, 12,  6,  8,  3, 13},
    '{ 2, 12,  6, 10,  0, 11,  8,  3,  4, 13,  7,  5, 15, 14,  1,  9},
    '{12,  5,  1, 15, 14, 13,  4, 10,  0,  7,  6,  3,  9,  2,  8, 11},
    '{13, 11,  7, 14, 12,  1,  3,  9,  5,  0, 15,  4,  8,  6,  2, 10},
    '{ 6, 15, 14,  9, 11,  3,  0,  8, 12,  2, 13,  7,  1,  4, 10,  5},
    '{10,  2,  8,  4,  7,  6,  1,  5, 15, 11, 14,  9,  3, 12, 13,  0}
  };

  logic [63:0]  cur_h [8];
  logic [63:0]  cur_m [16];
  logic [63:0]  cur_t0, cur_t1;
  logic         cur_f;
  logic [63:0]  exp_h [8];
  logic [63:0]  mv [16];
  logic [63:0]  msk;
  int           rot [4];

  int           checks = 0;
  int           errors = 0;

  logic [511:0] got, e0, e1, o0, o1, exp1, exp2;
  logic [511:0] outs [2];
  int           acc [2];
  int           lat, cyc, nacc, nout;
  bit           rb, stable, acc_now;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] rr(input logic [63:0] x, input int n, input int w);
    return ((x >> n) | (x << (w - n))) & msk;
  endfunction

  task automatic gm(input int a, input int b, input int c, input int d,
                    input logic [63:0] x, input logic [63:0] y, input int w);
    mv[a] = (mv[a] + mv[b] + x) & msk;
    mv[d] = rr(mv[d] ^ mv[a], rot[0], w);
    mv[c] = (mv[c] + mv[d]) & msk;
    mv[b] = rr(mv[b] ^ mv[c], rot[1], w);
    mv[a] = (mv[a] + mv[b] + y) & msk;
    mv[d] = rr(mv[d] ^ mv[a], rot[2], w);
    mv[c] = (mv[c] + mv[d]) & msk;
    mv[b] = rr(mv[b] ^ mv[c], rot[3], w);
  endtask

  // RFC 7693 compression on the cur_* block, result in exp_h.
  task automatic model(input int w, input int r);
    msk = (w == 64) ? 64'hffff_ffff_ffff_ffff : 64'h0000_0000_ffff_ffff;
    if (w == 64) rot = '{32, 24, 16, 63};
    else         rot = '{16, 12, 8, 7};
    for (int k = 0; k < 8; k++) begin
      mv[k]     = cur_h[k] & msk;
      mv[k + 8] = IV64[k] >> (64 - w);
    end
    mv[12] = mv[12] ^ (cur_t0 & msk);
    mv[13] = mv[13] ^ (cur_t1 & msk);
    if (cur_f) mv[14] = mv[14] ^ msk;
    for (int i = 0; i < r; i++) begin
      int s;
      s = i % 10;
      gm(0, 4,  8, 12, cur_m[SIG[s][0]],  cur_m[SIG[s][1]],  w);
      gm(1, 5,  9, 13, cur_m[SIG[s][2]],  cur_m[SIG[s][3]],  w);
      gm(2, 6, 10, 14, cur_m[SIG[s][4]],  cur_m[SIG[s][5]],  w);
      gm(3, 7, 11, 15, cur_m[SIG[s][6]],  cur_m[SIG[s][7]],  w);
      gm(0, 5, 10, 15, cur_m[SIG[s][8]],  cur_m[SIG[s][9]],  w);
      gm(1, 6, 11, 12, cur_m[SIG[s][10]], cur_m[SIG[s][11]], w);
      gm(2, 7,  8, 13, cur_m[SIG[s][12]], cur_m[SIG[s][13]], w);
      gm(3, 4,  9, 14, cur_m[SIG[s][14]], cur_m[SIG[s][15]], w);
    end
    for (int k = 0; k < 8; k++) exp_h[k] = (cur_h[k] & msk) ^ mv[k] ^ mv[k + 8];
  endtask

  function automatic logic [511:0] exp_packed(input int w);
    logic [511:0] p;
    p = '0;
    for (int k = 0; k < 8; k++) begin
      if (w == 64) p[64*k +: 64] = exp_h[k];
      else         p[32*k +: 32] = exp_h[k][31:0];
    end
    return p;
  endfunction

  task automatic drive(input int w);
    for (int k = 0; k < 8; k++) begin
      if (w == 64) h64_i[64*k +: 64] = cur_h[k];
      else         h32_i[32*k +: 32] = cur_h[k][31:0];
    end
    for (int k = 0; k < 16; k++) begin
      if (w == 64) m64_i[64*k +: 64] = cur_m[k];
      else         m32_i[32*k +: 32] = cur_m[k][31:0];
    end
    if (w == 64) begin
      t64_i = {cur_t1, cur_t0};
      f64_i = cur_f;
    end else begin
      t32_i = {cur_t1[31:0], cur_t0[31:0]};
      f32_i = cur_f;
    end
  endtask

  task automatic set_abc(input int w);
    for (int k = 0; k < 8; k++) cur_h[k] = IV64[k] >> (64 - w);
    cur_h[0] = cur_h[0] ^ ((w == 64) ? 64'h01010040 : 64'h01010020);
    for (int k = 0; k < 16; k++) cur_m[k] = '0;
    cur_m[0] = 64'h0000_0000_0063_6261;
    cur_t0   = 64'd3;
    cur_t1   = 64'd0;
    cur_f    = 1'b1;
  endtask

  task automatic set_rand();
    for (int k = 0; k < 8; k++)  cur_h[k] = {$urandom, $urandom};
    for (int k = 0; k < 16; k++) cur_m[k] = {$urandom, $urandom};
    cur_t0 = 64'($urandom_range(1, 5000));
    cur_t1 = 64'd0;
    cur_f  = 1'($urandom_range(0, 1));
  endtask

  // Issue the cur_* block, scramble inputs after acceptance, wait for valid_o.
  task automatic run_blk(input int w, output logic [511:0] res, output int lt, output bit rbad);
    int n;
    drive(w);
    if (w == 64) v64_i = 1'b1;
    else         v32_i = 1'b1;
    n = 0;
    while (!((w == 64) ? r64_o : r32_o) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL ready_wait: observed ready 0 expected 1");
    end
    tick();
    if (w == 64) begin
      v64_i = 1'b0;
      h64_i = {16{$urandom}};
      m64_i = {32{$urandom}};
      t64_i = {4{$urandom}};
      f64_i = ~f64_i;
    end else begin
      v32_i = 1'b0;
      h32_i = {8{$urandom}};
      m32_i = {16{$urandom}};
      t32_i = {2{$urandom}};
      f32_i = ~f32_i;
    end
    lt   = 0;
    rbad = 1'b0;
    while (!((w == 64) ? v64_o : v32_o) && lt < 100) begin
      if ((w == 64) ? r64_o : r32_o) rbad = 1'b1;
      tick();
      lt++;
    end
    res = (w == 64) ? h64_o : {256'b0, h32_o};
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    v64_i = 1'b0; f64_i = 1'b0; h64_i = '0; m64_i = '0; t64_i = '0; rdy64_i = 1'b1;
    v32_i = 1'b0; f32_i = 1'b0; h32_i = '0; m32_i = '0; t32_i = '0; rdy32_i = 1'b1;
    repeat (3) tick();
    chk("rst64_ready", r64_o, 1);
    chk("rst64_valid", v64_o, 0);
    chk("rst64_h", h64_o, 0);
    chk("rst32_ready", r32_o, 1);
    chk("rst32_valid", v32_o, 0);
    chk("rst32_h", h32_o, 0);
    reset = 1'b0;
    tick();

    // BLAKE2b "abc"
    set_abc(64);
    model(64, 12);
    run_blk(64, got, lat, rb);
    chk("abc64_latency", lat, 12);
    chk("abc64_ready_low", rb, 0);
    chk("abc64_h0", got[63:0], 64'h0D4D1C983FA580BA);
    chk("abc64_model", got, exp_packed(64));

    // BLAKE2s "abc" followed by a long output stall
    rdy32_i = 1'b0;
    set_abc(32);
    model(32, 10);
    e0 = exp_packed(32);
    run_blk(32, got, lat, rb);
    chk("abc32_latency", lat, 10);
    chk("abc32_ready_low", rb, 0);
    chk("abc32_h0", got[31:0], 32'h8C5E8C50);
    chk("abc32_model", got, e0);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) begin
        h32_i = {8{$urandom}};
        v32_i = 1'b1;
      end
      if (i == 6) v32_i = 1'b0;
      tick();
      if (h32_o !== got[255:0] || v32_o !== 1'b1 || r32_o !== 1'b0) stable = 1'b0;
    end
    chk("stall_stable", stable, 1);
    chk("stall_h", h32_o, e0);
    rdy32_i = 1'b1;
    tick();
    chk("handoff_valid_low", v32_o, 0);
    chk("handoff_ready_high", r32_o, 1);
    repeat (2) tick();
    chk("stall_pulse_ignored", r32_o, 1);

    // Back-to-back BLAKE2b blocks with valid_i held high
    set_abc(64);
    cur_f = 1'b0;
    model(64, 12);
    exp1 = exp_packed(64);
    drive(64);
    for (int k = 0; k < 8; k++)  cur_h[k] = exp_h[k];
    for (int k = 0; k < 16; k++) cur_m[k] = {$urandom, $urandom};
    cur_t0 = 64'd256;
    cur_t1 = 64'd0;
    cur_f  = 1'b1;
    model(64, 12);
    exp2 = exp_packed(64);
    cyc = 0; nacc = 0; nout = 0; acc = '{0, 0};
    outs[0] = '0; outs[1] = '0;
    v64_i = 1'b1;
    while (nout < 2 && cyc < 80) begin
      acc_now = r64_o && v64_i;
      if (v64_o) begin
        outs[nout] = h64_o;
        nout++;
      end
      if (acc_now && nacc < 2) begin
        acc[nacc] = cyc;
        nacc++;
      end
      tick();
      cyc++;
      if (acc_now && nacc == 1) drive(64);
      if (acc_now && nacc == 2) v64_i = 1'b0;
    end
    v64_i = 1'b0;
    chk("b2b_accepts", nacc, 2);
    chk("b2b_interval", acc[1] - acc[0], 14);
    chk("b2b_block1", outs[0], exp1);
    chk("b2b_block2", outs[1], exp2);

    // Asynchronous reset in the middle of a run
    set_abc(64);
    model(64, 12);
    drive(64);
    v64_i = 1'b1;
    tick();
    v64_i = 1'b0;
    repeat (5) tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", r64_o, 1);
    chk("midrst_valid", v64_o, 0);
    chk("midrst_h", h64_o, 0);
    #2 reset = 1'b0;
    tick();
    run_blk(64, got, lat, rb);
    chk("postrst_latency", lat, 12);
    chk("postrst_model", got, exp_packed(64));

    // Run-time f and t flags
    set_rand();
    cur_f = 1'b0;
    model(64, 12);
    e0 = exp_packed(64);
    run_blk(64, o0, lat, rb);
    chk("f0_model", o0, e0);
    cur_f = 1'b1;
    model(64, 12);
    e1 = exp_packed(64);
    run_blk(64, o1, lat, rb);
    chk("f1_model", o1, e1);
    chk("f_changes_result", (o0 != o1), 1);
    cur_f  = 1'b0;
    cur_t0 = 64'd0;
    cur_t1 = 64'd1;
    model(64, 12);
    run_blk(64, got, lat, rb);
    chk("thigh64_model", got, exp_packed(64));
    chk("thigh64_differs", (got != o0), 1);
    set_rand();
    cur_t1 = 64'd7;
    model(32, 10);
    run_blk(32, got, lat, rb);
    chk("thigh32_model", got, exp_packed(32));

    // Random blocks on both widths
    for (int i = 0; i < 3; i++) begin
      set_rand();
      model(64, 12);
      run_blk(64, got, lat, rb);
      chk("rand64_model", got, exp_packed(64));
      chk("rand64_latency", lat, 12);
      set_rand();
      model(32, 10);
      run_blk(32, got, lat, rb);
      chk("rand32_model", got, exp_packed(32));
      chk("rand32_latency", lat, 10);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/blake2_compress_hs.md
Name: blake2_compress_hs

Overview:
- Parametrised BLAKE2 compression function F; one width parameter selects BLAKE2b (W=64) or BLAKE2s (W=32).
- Computes one full round (8 G applications) per clock.
- Takes the byte offset t and the final-block flag f per block at run time.
- Uses a valid/ready handshake on input and output, so the hash-chaining controller can stall it; sits between the block buffer/padder and the chaining-state register.

Parameters:
- W, 64, word width; legal values 32 or 64. W=64 selects BLAKE2b IV and rotations (32,24,16,63); W=32 selects BLAKE2s IV and rotations (16,12,8,7).
- R, (W==64)?12:10, number of rounds, 1..15. Round i uses SIGMA[i mod 10].

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- valid_i  in  1  input block valid
- ready_o  out  1  block can accept input
- h_i  in  8W  chaining state, word k at [kW+W-1:kW]
- m_i  in  16W  message block, word k at [kW+W-1:kW]
- t_i  in  2W  byte offset counter; low word at [W-1:0]
- f_i  in  1  final-block flag
- valid_o  out  1  h_o valid
- ready_i  in  1  downstream accepts h_o
- h_o  out  8W  new chaining state, registered

Behaviour:
- Reset (async, active-high) forces:
  - state=IDLE, round counter rnd_q=0, valid_o=0, ready_o=1, h_o=0.
  - Data registers need not be reset.
- States: IDLE, RUN, DONE.
  - ready_o=1 only in IDLE.
  - valid_o=1 only in DONE.
- IDLE:
  - On valid_i&ready_o, capture h_q=h_i and m_q=m_i.
  - Load v_q[0..7]=h_i and v_q[8..15]=IV[0..7].
  - Then XOR v_q[12]^=t_i[W-1:0] and v_q[13]^=t_i[2W-1:W].
  - If f_i, also v_q[14]^={W{1}}.
  - Set rnd_q=0 and go to RUN.
  - Inputs are sampled only on this handshake edge; h_i, m_i, t_i and f_i may change afterwards.
- RUN:
  - Each edge, v_q <= ROUND(v_q, m_q, SIGMA[rnd_q mod 10]).
  - ROUND is a column step G(0,4,8,12), G(1,5,9,13), G(2,6,10,14), G(3,7,11,15) using message pairs s[0..7].
  - It is followed by a diagonal step G(0,5,10,15), G(1,6,11,12), G(2,7,8,13), G(3,4,9,14) using s[8..15].
  - The diagonal step operates on the column step's results.
  - G follows RFC 7693: adds mod 2^W, right rotations by R1..R4 for the selected W.
  - rnd_q increments each edge.
  - On the edge where rnd_q==R-1: compute h_o[k] <= h_q[k] ^ v'[k] ^ v'[k+8], where v' is that edge's ROUND output. Then go to DONE and set rnd_q=0.
- Mod-10 selection: a counter sig_q runs alongside rnd_q and wraps 9->0, so no divider is used. For R=12, rounds 10 and 11 use SIGMA[0] and SIGMA[1].
- Latency: valid_o rises exactly R cycles after the accepting edge, i.e. in the cycle following the Rth RUN edge.
- DONE:
  - h_o and valid_o are held stable while ready_i=0; the stall is unbounded.
  - On valid_o&ready_i: valid_o=0 next cycle, go to IDLE, ready_o=1 next cycle.
  - A new block cannot be accepted in the same cycle as the output handshake; minimum issue interval is R+2 cycles.
- valid_i while busy (RUN or DONE): ignored, no capture. The upstream must hold valid_i until ready_o.
- Width rules:
  - All adds are W-bit; carries are discarded.
  - The t halves are XORed as given; no carry or increment is applied inside the block.
- Reset asserted mid-RUN or in DONE: aborts immediately (asynchronously) to the IDLE reset values. No partial h_o is ever presented with valid_o=1.
- R=1: RUN lasts a single edge, then DONE.

Test Plan:
- BLAKE2b "abc", W=64, R=12:
  - Stimulus: h_i=IV with h[0]^=64'h01010040; m_i word0=64'h0000000000636261, others 0; t_i=3; f_i=1.
  - Required: h_o[0]=64'h0D4D1C983FA580BA; valid_o rises 12 cycles after accept; ready_o=0 throughout.
- BLAKE2s "abc", W=32, R=10:
  - Stimulus: h_i=IVs with h[0]^=32'h01010020; m0=32'h00636261; t_i=3; f_i=1.
  - Required: h_o[0]=32'h8C5E8C50; valid_o after 10 cycles.
- Output stall:
  - Stimulus: hold ready_i=0 for 20 cycles after valid_o.
  - Required: h_o and valid_o stable; ready_o=0; a second valid_i pulse during the stall is not captured. After ready_i=1, ready_o=1 on the next cycle.
- Back-to-back blocks (W=64):
  - Stimulus: valid_i held high with ready_i=1; block 1 is "abc" with f=0, block 2 has t=256.
  - Required: accepts exactly R+2 cycles apart; each h_o matches the C model.
- Async reset:
  - Stimulus: assert reset at round 5, between clock edges.
  - Required: valid_o=0 and ready_o=1 immediately; a fresh "abc" run afterwards gives the correct h_o.
- Run-time flags:
  - Stimulus: same block issued with f_i=0 versus f_i=1, and with t_i high word nonzero (t=2^64).
  - Required: results differ and match the C model; only v[13] is affected by the high word.
